chat_scan: RTL and testbench



---
 rtl/chat_pkg.sv | 13 +
 rtl/chat_scan_if.sv | 16 +
 rtl/chat_core.sv | 30 +++
 rtl/chat_scan.sv | 78 +++++++
 tb/tb_chat_scan.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chat_pkg.sv
// Shared constants and helpers for the time-multiplexed switch debouncer.
package chat_pkg;

    localparam int CHAT_N_CH = 4;
    localparam int CHAT_TH   = 3;
    localparam int CHAT_DIV  = 4;

    // Agreement counter width; never narrower than one bit, even for TH=1.
    function automatic int chat_cnt_w(input int th);
        return (th <= 2) ? 1 : $clog2(th);
    endfunction

endpackage

// File: rtl/chat_scan_if.sv
// Switch bank interface: scan enable and raw levels in, clean levels and change events out.
interface chat_scan_if #(
    parameter int N_CH = chat_pkg::CHAT_N_CH
);
    localparam int PTR_W = $clog2(N_CH);

    logic             en;
    logic [N_CH-1:0]  in;
    logic [N_CH-1:0]  out;
    logic             chg;
    logic [PTR_W-1:0] chg_ch;

    modport master (output en, in, input out, chg, chg_ch);
    modport slave  (input en, in, output out, chg, chg_ch);

endinterface

// File: rtl/chat_core.sv
// Single debounce step for one channel: compares a sample with the stable level.
module chat_core #(
    parameter int TH = 3,
    parameter int CW = 2
) (
    input  logic          sample_i,
    input  logic          stable_i,
    input  logic [CW-1:0] cnt_i,
    output logic          stable_o,
    output logic [CW-1:0] cnt_o,
    output logic          flip_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TH - 1);

    always_comb begin
        stable_o = stable_i;
        cnt_o    = '0;
        flip_o   = 1'b0;
        if (sample_i != stable_i) begin
            if (cnt_i == CNT_LAST) begin
                stable_o = ~stable_i;
                flip_o   = 1'b1;
            end else begin
                cnt_o = cnt_i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chat_scan.sv
// Round-robin debouncer: one chat_core shared by all channels, one channel per scan slot.
module chat_scan
    import chat_pkg::*;
#(
    parameter int N_CH = CHAT_N_CH,
    parameter int TH   = CHAT_TH,
    parameter int DIV  = CHAT_DIV
) (
    input  logic      clk,
    input  logic      rst,
    chat_scan_if.slave bus
);

    localparam int CW = chat_cnt_w(TH);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] PRE_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_CH - 1);

    logic [DW-1:0]           pre_q, pre_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [N_CH-1:0][CW-1:0] cnt_q;
    logic [N_CH-1:0]         out_q;
    logic                    chg_q;
    logic [PW-1:0]           chg_ch_q;

    logic          tick;
    logic          core_stable;
    logic          core_flip;
    logic [CW-1:0] core_cnt;

    assign tick = bus.en && (pre_q == PRE_LAST);

    // Pointer wrap is explicit so non-power-of-two banks never visit a ghost channel.
    always_comb begin
        pre_d = pre_q;
        ptr_d = ptr_q;
        if (bus.en) pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick)   ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    chat_core #(.TH(TH), .CW(CW)) u_core (
        .sample_i (bus.in[ptr_q]),
        .stable_i (out_q[ptr_q]),
        .cnt_i    (cnt_q[ptr_q]),
        .stable_o (core_stable),
        .cnt_o    (core_cnt),
        .flip_o   (core_flip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            chg_q    <= 1'b0;
            chg_ch_q <= '0;
        end else begin
            pre_q <= pre_d;
            ptr_q <= ptr_d;
            chg_q <= 1'b0;
            if (tick) begin
                cnt_q[ptr_q] <= core_cnt;
                out_q[ptr_q] <= core_stable;
                if (core_flip) begin
                    chg_q    <= 1'b1;
                    chg_ch_q <= ptr_q;
                end
            end
        end
    end

    assign bus.out    = out_q;
    assign bus.chg    = chg_q;
    assign bus.chg_ch = chg_ch_q;

endmodule

// File: tb/tb_chat_scan.sv
// Bench for chat_scan: directed scenarios plus random traffic against a slot-count model.
module tb_chat_scan;
    import chat_pkg::*;

    localparam int N   = 4;
    localparam int TH  = 3;
    localparam int DIV = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chat_scan_if #(.N_CH(N)) bus  ();
    chat_scan_if #(.N_CH(N)) bus2 ();

    chat_scan #(.N_CH(N), .TH(TH), .DIV(DIV)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    chat_scan #(.N_CH(N), .TH(1),  .DIV(1))   dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // Model: counts enabled edges since reset; every DIV-th one services the next channel in turn.
    int         m_n   [2];
    int         m_agr [2][N];
    logic [N-1:0] m_out [2];
    logic       m_chg [2];
    logic [1:0] m_chgch [2];

    task automatic m_step(input int id, input logic r, input logic e,
                          input logic [N-1:0] x, input int th, input int dv);
        int ch;
        if (r) begin
            m_n[id] = 0; m_out[id] = '0; m_chg[id] = 1'b0; m_chgch[id] = 2'd0;
            for (int i = 0; i < N; i++) m_agr[id][i] = 0;
        end else begin
            m_chg[id] = 1'b0;
            if (e) begin
                m_n[id]++;
                if (m_n[id] % dv == 0) begin
                    ch = (m_n[id] / dv - 1) % N;
                    if (x[ch] == m_out[id][ch]) m_agr[id][ch] = 0;
                    else if (m_agr[id][ch] == th - 1) begin
                        m_out[id][ch] = ~m_out[id][ch];
                        m_agr[id][ch] = 0;
                        m_chg[id]     = 1'b1;
                        m_chgch[id]   = 2'(ch);
                    end else m_agr[id][ch]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        m_step(0, rst,  bus.en,  bus.in,  TH, DIV);
        m_step(1, rst2, bus2.en, bus2.in, 1,  1);
    end

    task automatic do_reset(input logic [N-1:0] v);
        rst = 1'b1; bus.en = 1'b1; bus.in = v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.en = 1'b1; bus.in = 4'b1111;
        repeat (30) @(negedge clk);
        do_reset(4'b1111);
        checks++;
        if (bus.out !== 4'b0000 || bus.chg !== 1'b0 || bus.chg_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs out=%b chg=%b chg_ch=%0d want 0000/0/0", bus.out, bus.chg, bus.chg_ch);
        end
        checks++;
        if (dut.cnt_q !== '0 || dut.ptr_q !== 2'd0 || dut.pre_q !== '0) begin
            errors++;
            $display("FAIL reset_state cnt=%h ptr=%0d pre=%0d want 0/0/0", dut.cnt_q, dut.ptr_q, dut.pre_q);
        end
    endtask

    task automatic test_single();
        do_reset(4'b0001);
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            checks++;
            if (bus.out !== m_out[0] || bus.chg !== m_chg[0] || (m_chg[0] && bus.chg_ch !== m_chgch[0])) begin
                errors++;
                $display("FAIL single_model e=%0d out=%b chg=%b ch=%0d want %b/%b/%0d", e, bus.out, bus.chg, bus.chg_ch, m_out[0], m_chg[0], m_chgch[0]);
            end
            if (e == 17 || e == 18 || e == 19) begin
                checks++;
                if (bus.out !== ((e >= 18) ? 4'b0001 : 4'b0000) || bus.chg !== (e == 18) || (e == 18 && bus.chg_ch !== 2'd0)) begin
                    errors++;
                    $display("FAIL single_flip e=%0d out=%b chg=%b ch=%0d", e, bus.out, bus.chg, bus.chg_ch);
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(4'b0000);
        bus.in = 4'b0010;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            checks++;
            if (bus.out !== 4'b0000 || bus.chg !== 1'b0) begin
                errors++;
                $display("FAIL glitch_quiet e=%0d out=%b chg=%b want 0000/0", e, bus.out, bus.chg);
            end
            if (e == 4 || e == 12) begin
                checks++;
                if (dut.cnt_q[1] !== ((e == 4) ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("FAIL glitch_cnt e=%0d cnt1=%0d want %0d", e, dut.cnt_q[1], (e == 4) ? 1 : 0);
                end
            end
            if (e == 6) bus.in = 4'b0000;
        end
    endtask

    task automatic test_all();
        logic [N-1:0] want;
        do_reset(4'b1111);
        want = '0;
        for (int e = 1; e <= 26; e++) begin
            @(negedge clk);
            if (e >= 18 && e <= 24 && e % 2 == 0) want[(e - 18) / 2] = 1'b1;
            checks++;
            if (bus.out !== want || bus.chg !== (e >= 18 && e <= 24 && e % 2 == 0) ||
                (bus.chg && bus.chg_ch !== 2'((e - 18) / 2))) begin
                errors++;
                $display("FAIL all_order e=%0d out=%b chg=%b ch=%0d want out=%b", e, bus.out, bus.chg, bus.chg_ch, want);
            end
        end
    endtask

    task automatic test_enable();
        do_reset(4'b0001);
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            checks++;
            if (bus.out !== m_out[0] || bus.chg !== m_chg[0]) begin
                errors++;
                $display("FAIL enable_model e=%0d out=%b chg=%b want %b/%b", e, bus.out, bus.chg, m_out[0], m_chg[0]);
            end
            if (e == 20) begin
                checks++;
                if (dut.cnt_q[0] !== 2'd2 || bus.out !== 4'b0000) begin
                    errors++;
                    $display("FAIL enable_hold cnt0=%0d out=%b want 2/0000", dut.cnt_q[0], bus.out);
                end
            end
            if (e == 37 || e == 38) begin
                checks++;
                if (bus.out[0] !== (e == 38) || bus.chg !== (e == 38)) begin
                    errors++;
                    $display("FAIL enable_resume e=%0d out0=%b chg=%b", e, bus.out[0], bus.chg);
                end
            end
            if (e == 10) bus.en = 1'b0;
            if (e == 30) bus.en = 1'b1;
        end
    endtask

    task automatic test_rst_mid();
        do_reset(4'b0001);
        for (int e = 1; e <= 36; e++) begin
            @(negedge clk);
            if (e == 15) begin
                checks++;
                if (bus.out !== 4'b0000 || bus.chg !== 1'b0 || dut.cnt_q !== '0) begin
                    errors++;
                    $display("FAIL rstmid_clear out=%b chg=%b cnt=%h want 0", bus.out, bus.chg, dut.cnt_q);
                end
                rst = 1'b0;
            end
            checks++;
            if (bus.out !== m_out[0] || bus.chg !== m_chg[0]) begin
                errors++;
                $display("FAIL rstmid_model e=%0d out=%b chg=%b want %b/%b", e, bus.out, bus.chg, m_out[0], m_chg[0]);
            end
            if (e == 18 || e == 32 || e == 33) begin
                checks++;
                if (bus.out[0] !== (e == 33) || bus.chg !== (e == 33)) begin
                    errors++;
                    $display("FAIL rstmid_rise e=%0d out0=%b chg=%b", e, bus.out[0], bus.chg);
                end
            end
            if (e == 14) rst = 1'b1;
        end
    endtask

    task automatic test_th1();
        rst2 = 1'b1; bus2.en = 1'b1; bus2.in = '0;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            @(negedge clk);
            checks++;
            if (bus2.out !== m_out[1] || bus2.chg !== m_chg[1] || (m_chg[1] && bus2.chg_ch !== m_chgch[1])) begin
                errors++;
                $display("FAIL th1_model e=%0d out=%b chg=%b want %b/%b", e, bus2.out, bus2.chg, m_out[1], m_chg[1]);
            end
            if (e == 7 || e == 15 || e == 23) begin
                checks++;
                if (bus2.chg !== 1'b1 || bus2.chg_ch !== 2'd2 || bus2.out !== ((e == 15) ? 4'b0000 : 4'b0100)) begin
                    errors++;
                    $display("FAIL th1_follow e=%0d out=%b chg=%b ch=%0d", e, bus2.out, bus2.chg, bus2.chg_ch);
                end
            end
            if (e == 4 || e == 20) bus2.in = 4'b0100;
            if (e == 12) bus2.in = 4'b0000;
        end
    endtask

    task automatic test_random();
        do_reset(4'b0000);
        rst2 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out !== m_out[0] || bus.chg !== m_chg[0] || (m_chg[0] && bus.chg_ch !== m_chgch[0])) begin
                errors++;
                $display("FAIL rand_main c=%0d out=%b chg=%b ch=%0d want %b/%b/%0d", c, bus.out, bus.chg, bus.chg_ch, m_out[0], m_chg[0], m_chgch[0]);
            end
            checks++;
            if (bus2.out !== m_out[1] || bus2.chg !== m_chg[1] || (m_chg[1] && bus2.chg_ch !== m_chgch[1])) begin
                errors++;
                $display("FAIL rand_th1 c=%0d out=%b chg=%b ch=%0d want %b/%b/%0d", c, bus2.out, bus2.chg, bus2.chg_ch, m_out[1], m_chg[1], m_chgch[1]);
            end
            if ($urandom_range(0, 11) == 0) bus.in  = 4'($urandom);
            if ($urandom_range(0, 5)  == 0) bus2.in = 4'($urandom);
            bus.en  = ($urandom_range(0, 7) != 0);
            bus2.en = ($urandom_range(0, 5) != 0);
            rst  = ($urandom_range(0, 299) == 0);
            rst2 = ($urandom_range(0, 299) == 0);
        end
    endtask

    initial begin
        bus.en = 1'b1;  bus.in = '0;
        bus2.en = 1'b1; bus2.in = '0;
        test_reset();
        test_single();
        test_glitch();
        test_all();
        test_enable();
        test_rst_mid();
        test_th1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
